id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage sitting directly upstream of the execute ALU.
- Captures decoded operands and controls each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and produces the ALU's SrcA, SrcB and ALUControl.
- Detects load-use hazards, requests a decode stall, and inserts a bubble into execute.

---
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register, operand forwarding/select and load-use hazard; `define ID_EX_FORWARDING_EN for MEM/WB forwarding, else stall-until-WB
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_d,
  input  logic [DATA_WIDTH-1:0]     rd1_d,
  input  logic [DATA_WIDTH-1:0]     rd2_d,
  input  logic [DATA_WIDTH-1:0]     imm_d,
  input  logic [DATA_WIDTH-1:0]     pc_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic [3:0]                alu_control_d,
  input  logic                      alu_src_a_d,
  input  logic                      alu_src_b_d,
  input  logic                      reg_write_d,
  input  logic                      mem_write_d,
  input  logic                      mem_read_d,
  input  logic [1:0]                result_src_d,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      reg_write_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [DATA_WIDTH-1:0]     alu_result_m,
  input  logic                      reg_write_w,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic [DATA_WIDTH-1:0]     result_w,
  output logic [DATA_WIDTH-1:0]     src_a_e,
  output logic [DATA_WIDTH-1:0]     src_b_e,
  output logic [3:0]                alu_control_e,
  output logic [DATA_WIDTH-1:0]     write_data_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_e,
  output logic [DATA_WIDTH-1:0]     pc_e,
  output logic                      valid_e,
  output logic                      reg_write_e,
  output logic                      mem_write_e,
  output logic                      mem_read_e,
  output logic [1:0]                result_src_e,
  output logic                      hazard_o
);
  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_write;
    logic                      mem_read;
    logic                      alu_src_a;
    logic                      alu_src_b;
    logic [1:0]                result_src;
    logic [3:0]                alu_control;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } e_t;
  e_t                  r_e;
  e_t                  w_d;
  logic [DATA_WIDTH-1:0] w_fwd_a;
  logic [DATA_WIDTH-1:0] w_fwd_b;
  logic                w_hit_e;
  logic                w_hz_extra;
  assign w_d = '{valid: valid_d, reg_write: reg_write_d, mem_write: mem_write_d, mem_read: mem_read_d,
                 alu_src_a: alu_src_a_d, alu_src_b: alu_src_b_d, result_src: result_src_d,
                 alu_control: alu_control_d, rd1: rd1_d, rd2: rd2_d, imm: imm_d, pc: pc_d,
                 rs1: rs1_d, rs2: rs2_d, rd: rd_d};
  // E register: flush beats stall, stall beats the load-use bubble, otherwise capture decode
  always_ff @(posedge clk or posedge rst)
    if (rst) r_e <= '0;
    else if (flush_i || (!stall_i && hazard_o)) r_e <= '0;
    else if (!stall_i) r_e <= w_d;
  assign w_hit_e = valid_d && r_e.rd != '0 && (r_e.rd == rs1_d || r_e.rd == rs2_d);
`ifdef ID_EX_FORWARDING_EN
  assign w_fwd_a = (reg_write_m && rd_m != '0 && rd_m == r_e.rs1) ? alu_result_m :
                   (reg_write_w && rd_w != '0 && rd_w == r_e.rs1) ? result_w : r_e.rd1;
  assign w_fwd_b = (reg_write_m && rd_m != '0 && rd_m == r_e.rs2) ? alu_result_m :
                   (reg_write_w && rd_w != '0 && rd_w == r_e.rs2) ? result_w : r_e.rd2;
  assign w_hz_extra = 1'b0;
`else
  logic w_unused;
  assign w_fwd_a = r_e.rd1;
  assign w_fwd_b = r_e.rd2;
  assign w_hz_extra = (r_e.reg_write && w_hit_e) ||
                      (valid_d && reg_write_m && rd_m != '0 && (rd_m == rs1_d || rd_m == rs2_d));
  assign w_unused = ^{alu_result_m, result_w, reg_write_w, rd_w, r_e.rs1, r_e.rs2};
`endif
  assign hazard_o      = !flush_i && ((r_e.valid && r_e.mem_read && w_hit_e) || w_hz_extra);
  assign src_a_e       = r_e.alu_src_a ? r_e.pc : w_fwd_a;
  assign src_b_e       = r_e.alu_src_b ? r_e.imm : w_fwd_b;
  assign write_data_e  = w_fwd_b;
  assign alu_control_e = r_e.alu_control;
  assign rd_e          = r_e.rd;
  assign pc_e          = r_e.pc;
  assign valid_e       = r_e.valid;
  assign reg_write_e   = r_e.reg_write;
  assign mem_write_e   = r_e.mem_write;
  assign mem_read_e    = r_e.mem_read;
  assign result_src_e  = r_e.result_src;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a decode-record model
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_d, alu_src_a_d, alu_src_b_d, reg_write_d, mem_write_d, mem_read_d;
  logic [DW-1:0] rd1_d, rd2_d, imm_d, pc_d, alu_result_m, result_w;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rd_m, rd_w;
  logic [3:0] alu_control_d;
  logic [1:0] result_src_d;
  logic stall_i, flush_i, reg_write_m, reg_write_w;
  logic [DW-1:0] src_a_e, src_b_e, write_data_e, pc_e;
  logic [3:0] alu_control_e;
  logic [AW-1:0] rd_e;
  logic valid_e, reg_write_e, mem_write_e, mem_read_e, hazard_o;
  logic [1:0] result_src_e;
  always #5 clk = ~clk;
  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_control_d(alu_control_d), .alu_src_a_d(alu_src_a_d),
    .alu_src_b_d(alu_src_b_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .mem_read_d(mem_read_d),
    .result_src_d(result_src_d), .stall_i(stall_i), .flush_i(flush_i), .reg_write_m(reg_write_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_e(alu_control_e), .write_data_e(write_data_e),
    .rd_e(rd_e), .pc_e(pc_e), .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .mem_read_e(mem_read_e), .result_src_e(result_src_e), .hazard_o(hazard_o));
  typedef struct packed {
    logic valid, rw, mw, mr, asa, asb;
    logic [1:0] rs;
    logic [3:0] ac;
    logic [DW-1:0] rd1, rd2, imm, pc;
    logic [AW-1:0] r1, r2, rd;
  } rec_t;
  rec_t m = '0;
  int n_chk = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic rec_t decoded();
    return '{valid: valid_d, rw: reg_write_d, mw: mem_write_d, mr: mem_read_d, asa: alu_src_a_d,
             asb: alu_src_b_d, rs: result_src_d, ac: alu_control_d, rd1: rd1_d, rd2: rd2_d,
             imm: imm_d, pc: pc_d, r1: rs1_d, r2: rs2_d, rd: rd_d};
  endfunction
  function automatic logic reads(input logic [AW-1:0] r);
    return valid_d && r != 0 && (r == rs1_d || r == rs2_d);
  endfunction
  function automatic logic exp_hz();
    logic h;
    h = m.valid && m.mr && reads(m.rd);
`ifndef ID_EX_FORWARDING_EN
    h = h || (m.rw && reads(m.rd)) || (reg_write_m && reads(rd_m));
`endif
    return h && !flush_i;
  endfunction
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] rs, input logic [DW-1:0] v);
`ifdef ID_EX_FORWARDING_EN
    if (reg_write_m && rd_m != 0 && rd_m == rs) return alu_result_m;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return result_w;
`endif
    return v;
  endfunction
  task automatic check_comb();
    #1;
    check("hazard", hazard_o, exp_hz());
    check("src_a", src_a_e, m.asa ? m.pc : fwd(m.r1, m.rd1));
    check("src_b", src_b_e, m.asb ? m.imm : fwd(m.r2, m.rd2));
    check("wdata", write_data_e, fwd(m.r2, m.rd2));
  endtask
  task automatic check_regs();
    check("valid_e", valid_e, m.valid);
    check("reg_write_e", reg_write_e, m.rw);
    check("mem_write_e", mem_write_e, m.mw);
    check("mem_read_e", mem_read_e, m.mr);
    check("result_src_e", result_src_e, m.rs);
    check("alu_control_e", alu_control_e, m.ac);
    check("rd_e", rd_e, m.rd);
    check("pc_e", pc_e, m.pc);
  endtask
  task automatic cycle();
    rec_t nxt;
    check_comb();
    nxt = flush_i ? '0 : stall_i ? m : exp_hz() ? '0 : decoded();
    @(posedge clk);
    m = nxt;
    @(negedge clk);
    check_regs();
  endtask
  task automatic set_idle();
    {valid_d, alu_src_a_d, alu_src_b_d, reg_write_d, mem_write_d, mem_read_d} = '0;
    {rd1_d, rd2_d, imm_d, pc_d, alu_result_m, result_w} = '0;
    {rs1_d, rs2_d, rd_d, rd_m, rd_w, alu_control_d, result_src_d} = '0;
    {stall_i, flush_i, reg_write_m, reg_write_w} = '0;
  endtask
  task automatic randomize_inputs();
    valid_d = 1'($urandom_range(0, 3) != 0);
    rd1_d = $urandom(); rd2_d = $urandom(); imm_d = $urandom(); pc_d = $urandom();
    alu_result_m = $urandom(); result_w = $urandom();
    rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3)); rd_d = AW'($urandom_range(0, 3));
    rd_m = AW'($urandom_range(0, 3)); rd_w = AW'($urandom_range(0, 3));
    alu_control_d = 4'($urandom_range(0, 10)); result_src_d = 2'($urandom());
    {alu_src_a_d, alu_src_b_d, reg_write_d, mem_write_d, mem_read_d, reg_write_m, reg_write_w} = 7'($urandom());
    stall_i = 1'($urandom_range(0, 7) == 0);
    flush_i = 1'($urandom_range(0, 9) == 0);
  endtask
  initial begin
    set_idle();
    repeat (2) @(negedge clk);
    check_regs();
    check_comb();
    rst = 1'b0;
    cycle();
    check("idle_valid", valid_e, 1'b0);
    check("idle_hz", hazard_o, 1'b0);
    set_idle(); valid_d = 1'b1; rd1_d = 5; rd2_d = 7;
    cycle();
    check("cap_a", src_a_e, 32'd5);
    check("cap_b", src_b_e, 32'd7);
    check("cap_ac", alu_control_e, 4'b0000);
    set_idle(); valid_d = 1'b1; rs1_d = 3; rd1_d = 32'h11;
    cycle();
    set_idle(); stall_i = 1'b1;
    reg_write_m = 1'b1; rd_m = 3; alu_result_m = 32'hAA;
    reg_write_w = 1'b1; rd_w = 3; result_w = 32'hBB;
    #1;
`ifdef ID_EX_FORWARDING_EN
    check("fwd_mem", src_a_e, 32'hAA);
    reg_write_m = 1'b0; #1;
    check("fwd_wb", src_a_e, 32'hBB);
`else
    check("nofwd_mem", src_a_e, 32'h11);
    reg_write_m = 1'b0; #1;
    check("nofwd_wb", src_a_e, 32'h11);
`endif
    cycle();
    set_idle(); valid_d = 1'b1; rd1_d = 32'h22;
    cycle();
    set_idle(); reg_write_m = 1'b1; alu_result_m = 32'hAA; reg_write_w = 1'b1; result_w = 32'hBB;
    #1 check("x0_nofwd", src_a_e, 32'h22);
    cycle();
    set_idle(); valid_d = 1'b1; mem_read_d = 1'b1; reg_write_d = 1'b1; rd_d = 4;
    cycle();
    set_idle(); valid_d = 1'b1; rs2_d = 4;
    #1 check("lu_hz", hazard_o, 1'b1);
    cycle();
    check("lu_bubble_v", valid_e, 1'b0);
    check("lu_bubble_mr", mem_read_e, 1'b0);
    #1 check("lu_once", hazard_o, 1'b0);
    cycle();
    set_idle(); valid_d = 1'b1; reg_write_d = 1'b1; rd_d = 9; alu_control_d = 4'd5;
    cycle();
    flush_i = 1'b1; stall_i = 1'b1;
    cycle();
    check("fl_valid", valid_e, 1'b0);
    check("fl_rw", reg_write_e, 1'b0);
    check("fl_ac", alu_control_e, 4'd0);
    set_idle(); valid_d = 1'b1; reg_write_d = 1'b1; rd_d = 9; alu_control_d = 4'd5; pc_d = 32'h100;
    cycle();
    set_idle(); stall_i = 1'b1; valid_d = 1'b1; alu_control_d = 4'd2; pc_d = 32'h200;
    repeat (3) cycle();
    check("stall_ac", alu_control_e, 4'd5);
    check("stall_pc", pc_e, 32'h100);
`ifndef ID_EX_FORWARDING_EN
    set_idle(); valid_d = 1'b1; reg_write_d = 1'b1; rd_d = 5;
    cycle();
    set_idle(); valid_d = 1'b1; rs1_d = 5; rd1_d = 32'h55;
    #1 check("raw_hz_e", hazard_o, 1'b1);
    cycle();
    reg_write_m = 1'b1; rd_m = 5;
    #1 check("raw_hz_m", hazard_o, 1'b1);
    cycle();
    reg_write_m = 1'b0; reg_write_w = 1'b1; rd_w = 5; result_w = 32'h99;
    #1 check("raw_hz_w", hazard_o, 1'b0);
    cycle();
    set_idle();
    #1 check("raw_rf_val", src_a_e, 32'h55);
`endif
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      cycle();
    end
    set_idle(); valid_d = 1'b1; mem_read_d = 1'b1; rd_d = 6; pc_d = 32'h44;
    cycle();
    valid_d = 1'b1; mem_read_d = 1'b0; rs1_d = 6; stall_i = 1'b1;
    #2 rst = 1'b1;
    m = '0;
    #1 check_regs();
    check_comb();
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    cycle();
    check("post_rst_v", valid_e, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
